// File: rtl/intr_ctrl_pkg.sv
// Shared types and constants for the CPU interrupt controller.
// Source bit indices match the intr_status bit layout read back through VID_CTRL.
package intr_ctrl_pkg;

  typedef enum logic [1:0] {
    INTR_IDLE    = 2'd0,
    INTR_ASSERT  = 2'd1,
    INTR_HOLDOFF = 2'd2
  } intr_state_t;

  localparam int INTR_NUM         = 4;
  localparam int INTR_PULSE       = 4;
  localparam int INTR_HOLDOFF_LEN = 8;

  localparam int INTR_VIDEO  = 0;
  localparam int INTR_COPPER = 1;
  localparam int INTR_BLIT   = 2;
  localparam int INTR_DRAW   = 3;

  // Counter must hold the larger of the two load values, and is never narrower than 1 bit.
  function automatic int intr_cnt_w(input int pulse, input int holdoff);
    int m;
    m = (pulse > holdoff) ? pulse : holdoff;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/intr_ctrl.sv
// Sticky interrupt status with mask/clear, driving a stretched CPU interrupt pulse
// of fixed width followed by a minimum low hold-off before any re-assertion.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int NUM_INTR       = INTR_NUM,
  parameter int PULSE_CYCLES   = INTR_PULSE,
  parameter int HOLDOFF_CYCLES = INTR_HOLDOFF_LEN
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic [NUM_INTR-1:0] intr_signal_i,
  input  logic [NUM_INTR-1:0] intr_mask_i,
  input  logic [NUM_INTR-1:0] intr_clear_i,
  output logic [NUM_INTR-1:0] intr_status_o,
  output logic                intr_pending_o,
  output logic                bus_intr_o
);

  localparam int CNT_W = intr_cnt_w(PULSE_CYCLES, HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  logic [NUM_INTR-1:0] r_status;
  logic [NUM_INTR-1:0] r_mask_q;
  logic                r_pending;
  logic                r_bus;
  logic                r_retrig;
  intr_state_t         r_state;
  logic [CNT_W-1:0]    r_cnt;

  logic [NUM_INTR-1:0] w_status_next;
  logic                w_trigger;
  logic                w_any_active;
  logic                w_go;

  // Set beats clear so an event landing on the same cycle as the CPU ack is kept.
  assign w_status_next = (r_status & ~intr_clear_i) | intr_signal_i;

  // New event on an idle bit, or a mask bit just enabled over an already-pending bit.
  assign w_trigger = |((intr_signal_i & intr_mask_i & ~r_status)
                     | (r_status & ~intr_clear_i & intr_mask_i & ~r_mask_q));

  assign w_any_active = |(w_status_next & intr_mask_i);

  // A remembered retrigger is dropped once the CPU has acked every enabled source.
  assign w_go = w_trigger | (r_retrig & w_any_active);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_status  <= '0;
      r_mask_q  <= '0;
      r_pending <= 1'b0;
      r_bus     <= 1'b0;
      r_retrig  <= 1'b0;
      r_state   <= INTR_IDLE;
      r_cnt     <= '0;
    end else begin
      r_status  <= w_status_next;
      r_mask_q  <= intr_mask_i;
      r_pending <= w_any_active;

      case (r_state)
        INTR_IDLE: begin
          r_retrig <= 1'b0;
          if (w_go) begin
            r_state <= INTR_ASSERT;
            r_cnt   <= PULSE_LOAD;
            r_bus   <= 1'b1;
          end
        end

        INTR_ASSERT: begin
          if (w_trigger) r_retrig <= 1'b1;
          if (r_cnt == '0) begin
            r_bus <= 1'b0;
            // With no hold-off, IDLE still provides the single low cycle between edges.
            if (HOLDOFF_CYCLES > 0) begin
              r_state <= INTR_HOLDOFF;
              r_cnt   <= HOLD_LOAD;
            end else begin
              r_state <= INTR_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        INTR_HOLDOFF: begin
          if (r_cnt == '0) begin
            r_retrig <= 1'b0;
            if (w_go) begin
              r_state <= INTR_ASSERT;
              r_cnt   <= PULSE_LOAD;
              r_bus   <= 1'b1;
            end else begin
              r_state <= INTR_IDLE;
            end
          end else begin
            if (w_trigger) r_retrig <= 1'b1;
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: begin
          r_state <= INTR_IDLE;
          r_bus   <= 1'b0;
        end
      endcase
    end
  end

  assign intr_status_o  = r_status;
  assign intr_pending_o = r_pending;
  assign bus_intr_o     = r_bus;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench: stimulus pushes expected pulses (start cycle, width); a negedge
// monitor pops them on each rising edge of bus_intr_o and checks width and gap.
module tb_intr_ctrl;
  import intr_ctrl_pkg::*;

  typedef struct {
    int start;
    int width;
  } pulse_t;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [3:0] intr_signal_i = '0;
  logic [3:0] intr_mask_i = '0;
  logic [3:0] intr_clear_i = '0;
  logic [3:0] intr_status_o;
  logic       intr_pending_o;
  logic       bus_intr_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  pulse_t exp_q[$];
  bit soak = 1'b0;

  intr_ctrl dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .intr_signal_i  (intr_signal_i),
    .intr_mask_i    (intr_mask_i),
    .intr_clear_i   (intr_clear_i),
    .intr_status_o  (intr_status_o),
    .intr_pending_o (intr_pending_o),
    .bus_intr_o     (bus_intr_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic [3:0] c);
    intr_signal_i = s;
    intr_clear_i  = c;
    idle(1);
    intr_signal_i = '0;
    intr_clear_i  = '0;
  endtask

  task automatic expect_pulse(input int start, input int width);
    pulse_t p;
    p.start = start;
    p.width = width;
    exp_q.push_back(p);
  endtask

  // Monitor
  logic prev_bus = 1'b0;
  bit   have_fall = 1'b0;
  bit   rst_seen = 1'b1;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  int   cur_w = 4;

  always @(negedge clk) begin
    pulse_t p;
    if (reset_i) rst_seen = 1'b1;
    if (bus_intr_o === 1'b1 && prev_bus === 1'b0) begin
      if (have_fall && !rst_seen) begin
        checks++;
        if (cyc - fall_cyc < 8) begin
          failures++;
          $display("FAIL gap: got %0d low cycles expected >= 8 (cycle %0d)", cyc - fall_cyc, cyc);
        end
      end
      rst_seen = 1'b0;
      rise_cyc = cyc;
      cur_w = 4;
      if (!soak) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: got rise at cycle %0d expected none", cyc);
        end else begin
          p = exp_q.pop_front();
          cur_w = p.width;
          chk("pulse_start", cyc, p.start);
        end
      end
    end
    if (bus_intr_o === 1'b0 && prev_bus === 1'b1) begin
      chk("pulse_width", cyc - rise_cyc, cur_w);
      fall_cyc = cyc;
      have_fall = 1'b1;
    end
    prev_bus = bus_intr_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [3:0] s;
    logic [3:0] c;

    // Reset
    idle(3);
    chk("rst_status", int'(intr_status_o), 0);
    chk("rst_pending", int'(intr_pending_o), 0);
    chk("rst_bus", int'(bus_intr_o), 0);
    reset_i = 1'b0;
    intr_mask_i = 4'hF;
    idle(2);

    // Basic pulse
    t0 = cyc;
    expect_pulse(t0 + 1, 4);
    drive(4'b0001, 4'b0000);
    chk("basic_status", int'(intr_status_o), 1);
    chk("basic_pending", int'(intr_pending_o), 1);
    chk("basic_bus", int'(bus_intr_o), 1);
    idle(14);
    chk("basic_status_sticky", int'(intr_status_o), 1);
    drive(4'b0000, 4'b0001);
    chk("basic_status_clr", int'(intr_status_o), 0);
    chk("basic_pending_clr", int'(intr_pending_o), 0);

    // Masked source, then enable mask
    intr_mask_i = 4'b0000;
    idle(1);
    drive(4'b0010, 4'b0000);
    chk("mask_status", int'(intr_status_o), 2);
    chk("mask_pending", int'(intr_pending_o), 0);
    chk("mask_bus", int'(bus_intr_o), 0);
    intr_mask_i = 4'b0010;
    expect_pulse(cyc + 1, 4);
    idle(1);
    chk("unmask_bus", int'(bus_intr_o), 1);
    chk("unmask_pending", int'(intr_pending_o), 1);
    idle(14);

    // Re-signal on an already pending bit
    drive(4'b0010, 4'b0000);
    idle(14);
    chk("resig_status", int'(intr_status_o), 2);
    drive(4'b0000, 4'b0010);
    chk("resig_clr", int'(intr_status_o), 0);

    // Hold-off
    intr_mask_i = 4'hF;
    idle(1);
    t0 = cyc;
    expect_pulse(t0 + 1, 4);
    expect_pulse(t0 + 13, 4);
    drive(4'b0001, 4'b0000);
    idle(1);
    drive(4'b0000, 4'b0001);
    drive(4'b0001, 4'b0000);
    idle(25);
    drive(4'b0000, 4'b0001);
    chk("hold_status_clr", int'(intr_status_o), 0);

    // Simultaneous set/clear, then clear-all kills the retrigger
    t0 = cyc;
    expect_pulse(t0 + 1, 4);
    drive(4'b0001, 4'b0001);
    chk("simul_status", int'(intr_status_o), 1);
    idle(1);
    drive(4'b0100, 4'b0000);
    chk("simul_status2", int'(intr_status_o), 5);
    idle(3);
    drive(4'b0000, 4'b1111);
    chk("simul_clr_all", int'(intr_status_o), 0);
    idle(20);
    chk("simul_no_repulse", int'(bus_intr_o), 0);

    // Reset in the second ASSERT cycle
    t0 = cyc;
    expect_pulse(t0 + 1, 2);
    drive(4'b0001, 4'b0000);
    idle(1);
    reset_i = 1'b1;
    idle(1);
    reset_i = 1'b0;
    chk("midrst_bus", int'(bus_intr_o), 0);
    chk("midrst_status", int'(intr_status_o), 0);
    chk("midrst_pending", int'(intr_pending_o), 0);
    idle(1);
    expect_pulse(cyc + 1, 4);
    drive(4'b1000, 4'b0000);
    chk("postrst_status", int'(intr_status_o), 8);
    idle(14);
    drive(4'b0000, 4'b1000);

    // Soak: only width and gap are checked
    soak = 1'b1;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 19) == 0) intr_mask_i = 4'($urandom);
      drive(s, c);
    end
    idle(30);
    soak = 1'b0;
    drive(4'b0000, 4'b1111);
    idle(2);

    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_bus", int'(bus_intr_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
